// File: rtl/serial_parity_checker_pkg.sv
// Shared constants for the serial parity checker: FSM encodings, line levels, parity senses.
// No logic; imported by the top and the bench-facing interface users.
// Encodings are fixed so waveforms and debug dumps read the same across builds.
package serial_parity_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bundle of the serial input strobe and the decoded-frame result signals.
// Master drives the line (sin/sin_valid) and observes results; slave is the checker.
// No flow control: sin_valid is a pure strobe, results are single-cycle pulses plus held flags.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              sin;
    logic              sin_valid;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output sin, sin_valid,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  sin, sin_valid,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_parity_checker_parity_accum.sv
// Running XOR parity over a stream of bits.
// Latency: parity reflects all enabled bits up to the previous rising edge.
// No backpressure: en gates accumulation, clear has priority over en.
module parity_accum (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic parity
);
    logic parity_q;
    logic parity_d;

    // XOR feedback: fold the incoming bit into the accumulated parity
    always_comb begin
        parity_d = parity_q;
        if (clear) begin
            parity_d = 1'b0;
        end else if (en) begin
            parity_d = parity_q ^ bit_in;
        end
    end

    // Parity register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
endmodule

// File: rtl/serial_parity_checker.sv
// Receives start/data(LSB first)/parity/stop frames one bit per sin_valid strobe and checks them.
// Latency: data_valid pulses one clk after the cycle that samples the stop bit.
// No backpressure: results are a one-cycle pulse; data_out and error flags hold until the next frame.
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input logic clk,
    input logic reset,
    serial_parity_checker_if.slave bus
);
    import serial_parity_checker_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W:0]   shift_ext;
    logic              par_ok_q, par_ok_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              acc_clr;
    logic              acc_en;
    logic              acc_parity;
    logic              par_sel;

    // Expected total XOR of data+parity bits: 0 for even parity, 1 for odd
    assign par_sel = (PARITY_ODD != PARITY_EVEN);

    parity_accum u_parity_accum (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clr),
        .en     (acc_en),
        .bit_in (bus.sin),
        .parity (acc_parity)
    );

    // Next-state and result computation; nothing moves on cycles without sin_valid
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        shift_ext    = {bus.sin, shift_q} >> 1;
        par_ok_d     = par_ok_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        if (bus.sin_valid) begin
            case (state_q)
                IDLE: begin
                    // Idle-line 1s are ignored; a 0 is the start bit
                    if (bus.sin == START_LVL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                        acc_clr = 1'b1;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting in at the MSB leaves the word aligned
                    shift_d = shift_ext[DATA_W-1:0];
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    par_ok_d = ((acc_parity ^ bus.sin) == par_sel);
                    state_d  = STOP;
                end
                STOP: begin
                    // A bad stop bit still completes the frame; it is only flagged
                    state_d      = IDLE;
                    data_valid_d = 1'b1;
                    data_out_d   = shift_q;
                    parity_err_d = !par_ok_q;
                    frame_err_d  = (bus.sin != STOP_LVL);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker: directed frames push expected results,
// an independent negedge monitor pops and compares on every data_valid pulse.
module tb_serial_parity_checker;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   errors;
    int   pulses;
    exp_t exp_q[$];
    exp_t last_exp;
    logic prev_pulse;

    serial_parity_checker_if #(.DATA_W(8)) bus ();

    serial_parity_checker #(.DATA_W(8), .PARITY_ODD(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every pulse against the oldest expected frame; the cycle after a pulse
    // data_valid must be low and the results must still hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_pulse) begin
                check("pulse_width", {31'd0, bus.data_valid}, 32'd0);
                check("hold_data", {24'd0, bus.data_out}, {24'd0, last_exp.data});
                check("hold_perr", {31'd0, bus.parity_err}, {31'd0, last_exp.perr});
                check("hold_ferr", {31'd0, bus.frame_err}, {31'd0, last_exp.ferr});
                prev_pulse = 1'b0;
            end else if (bus.data_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_pulse: data_valid high with data %0h, expected none", bus.data_out);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("data_out", {24'd0, bus.data_out}, {24'd0, last_exp.data});
                    check("parity_err", {31'd0, bus.parity_err}, {31'd0, last_exp.perr});
                    check("frame_err", {31'd0, bus.frame_err}, {31'd0, last_exp.ferr});
                    prev_pulse = 1'b1;
                end
            end
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // One clock of line activity; inputs change 1 time unit after the rising edge
    task automatic cyc(input logic v, input logic b);
        bus.sin_valid = v;
        bus.sin       = b;
        @(posedge clk);
        #1;
        bus.sin_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int maxgap);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        for (int g = 0; g < gap; g++) cyc(1'b0, ~b);
        cyc(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input logic e_perr, input logic e_ferr, input int maxgap);
        exp_t e;
        e.data = d;
        e.perr = e_perr;
        e.ferr = e_ferr;
        exp_q.push_back(e);
        send_bit(1'b0, maxgap);
        for (int i = 0; i < 8; i++) send_bit(d[i], maxgap);
        send_bit(par, maxgap);
        send_bit(stp, maxgap);
        // Stop bit was sampled on the edge just passed: result must already be visible
        check("latency", {31'd0, bus.data_valid}, 32'd1);
    endtask

    initial begin
        tests         = 0;
        errors        = 0;
        pulses        = 0;
        prev_pulse    = 1'b0;
        last_exp      = '0;
        bus.sin       = 1'b1;
        bus.sin_valid = 1'b0;
        reset         = 1'b1;
        #3;
        check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        check("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
        check("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b1);

        // Good frame, then wrong parity, then bad stop bit
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);

        // Abort a frame of 0xFF after four data bits
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_data_out", {24'd0, bus.data_out}, 32'd0);
        check("abort_frame_err", {31'd0, bus.frame_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
        check("abort_no_restart", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1);

        // Idle-line 1s, then a frame with random strobe gaps
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
        check("idle_ones_busy", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        cyc(1'b0, 1'b1);

        // Back-to-back frames without a gap
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);

        check("pulse_count", pulses, 32'd7);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 Parameter DATA_W, default 8: number of data bits per frame, legal range 1..16.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port sin, input, 1: serial bit, sampled only when sin_valid=1.
REQ-006 Port sin_valid, input, 1: bit strobe; one frame bit per cycle where high.
REQ-007 Port data_out, output, DATA_W: last received data word.
REQ-008 Port data_valid, output, 1: one-cycle pulse, frame complete.
REQ-009 Port parity_err, output, 1: parity mismatch on last frame.
REQ-010 Port frame_err, output, 1: stop bit was 0 on last frame.
REQ-011 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 The frame SHALL be start bit (0), DATA_W data bits LSB first, one parity bit, one stop bit (1).
REQ-013 The FSM SHALL have states IDLE, DATA, PAR, STOP, advancing only on cycles with sin_valid=1.
REQ-014 IDLE: sin_valid=1 with sin=0 SHALL go to DATA, clearing bit counter, shift register and running parity; sin=1 SHALL be ignored.
REQ-015 DATA: each valid bit SHALL shift into the MSB of the shift register (right shift) and XOR into running parity; after bit DATA_W-1, go to PAR.
REQ-016 PAR: the valid bit SHALL set parity_ok = ((running_parity XOR bit) == PARITY_ODD); go to STOP.
REQ-017 STOP: on the valid bit, the block SHALL go to IDLE and, on the next rising edge, drive data_out=shift register, parity_err=!parity_ok, frame_err=!sin, data_valid=1.
REQ-018 data_valid SHALL be high for exactly one cycle per frame; the stop bit is accepted even when sin=0 (frame_err flags it).
REQ-019 data_out, parity_err, frame_err SHALL hold until the next data_valid.
REQ-020 Latency: data_valid SHALL rise one clk after the cycle sampling the stop bit.
REQ-021 A start bit on the cycle right after the stop bit SHALL be accepted (back-to-back frames, no gap).
REQ-022 Cycles with sin_valid=0 in any state SHALL leave all state and outputs unchanged, except that data_valid SHALL still return to 0.
REQ-023 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-024 Reset SHALL asynchronously force state=IDLE, counter=0, shift register=0, running parity=0.
REQ-025 Reset SHALL force data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-026 Reset mid-frame SHALL discard the partial frame without a data_valid pulse.

Structure
REQ-027 A shared package/include SHALL hold the state encodings (IDLE=0, DATA=1, PAR=2, STOP=3), START_LVL=0, STOP_LVL=1, and the PARITY_EVEN/PARITY_ODD constants.
REQ-028 The running parity SHALL live in one sub-module, parity_accum (clk, reset, clear, en, bit_in, parity), built from XOR feedback.

Verification
REQ-029 Frame 0xA5, parity 0, stop 1 -> data_valid for 1 cycle, data_out=0xA5, parity_err=0, frame_err=0.
REQ-030 Frame 0x07, parity 0 (wrong; needs 1), stop 1 -> data_out=0x07, parity_err=1, frame_err=0.
REQ-031 Frame 0x3C, parity 0, stop 0 -> data_out=0x3C, parity_err=0, frame_err=1.
REQ-032 Reset pulse after 4 data bits of 0xFF, then frame 0x3C -> no pulse for the aborted frame, busy=0 after reset, then data_out=0x3C.
REQ-033 Frame 0x5A with 0-3 random idle cycles (sin_valid=0) between bits, preceded by 10 idle-line 1s -> single pulse, data_out=0x5A, no errors.
REQ-034 Back-to-back frames 0x01 (parity 1) then 0xFF (parity 0) with no gap -> two pulses, data_out 0x01 then 0xFF, both error-free.
